// File: rtl/shape_edge_walker_if.sv
// Handshake bundle between the instruction stage, the edge walker and the framebuffer writer.
// Ports: in_valid/in_ready/points/shape carry the shape request.
//        pix_valid/pix_ready/pix_x/pix_y carry the pixel stream; done marks the end of a shape.
interface shape_edge_walker_if #(
  parameter int width  = 4,
  parameter int height = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic [4*(width+height)-1:0]   points;
  logic                          shape;
  logic                          pix_valid;
  logic                          pix_ready;
  logic [width-1:0]              pix_x;
  logic [height-1:0]             pix_y;
  logic                          done;

  // master: the side that issues shapes and consumes pixels
  modport master (
    output in_valid, points, shape, pix_ready,
    input  in_ready, pix_valid, pix_x, pix_y, done
  );

  // slave: the edge walker itself
  modport slave (
    input  in_valid, points, shape, pix_ready,
    output in_ready, pix_valid, pix_x, pix_y, done
  );
endinterface

// File: rtl/shape_edge_walker.sv
// Walks every edge of a triangle or square with Bresenham stepping, one pixel per accepted cycle.
// Latency: accept at edge N -> SETUP in cycle N+1 -> first pixel in cycle N+2; one SETUP cycle per edge.
// Backpressure: pixel outputs hold while pix_valid && !pix_ready; in_ready only asserted in IDLE.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of shape_edge_walker_if).
module shape_edge_walker #(
  parameter int width  = 4,
  parameter int height = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  shape_edge_walker_if.slave   bus
);

  localparam int PW = width + height;
  localparam int EW = ((width > height) ? width : height) + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [4*PW-1:0]        pts_q, pts_d;
  logic                   shape_q, shape_d;
  logic [1:0]             edge_q, edge_d;
  logic [width-1:0]       cur_x_q, cur_x_d;
  logic [height-1:0]      cur_y_q, cur_y_d;
  logic signed [width:0]  dx_q, dx_d;
  logic signed [height:0] dy_q, dy_d;
  logic signed [EW-1:0]   err_q, err_d;
  logic                   sx_neg_q, sx_neg_d;
  logic                   sy_neg_q, sy_neg_d;

  // Unpacked vertices P1..P4 (index 0..3)
  logic [width-1:0]  vx [4];
  logic [height-1:0] vy [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vx[i] = pts_q[i*PW +: width];
      vy[i] = pts_q[i*PW + width +: height];
    end
  end

  // Start/end vertex of the current edge. The square visits P4 before P3
  // so that its outline goes round the perimeter rather than across it.
  logic [1:0] si, ei;
  always_comb begin
    si = 2'd0;
    ei = 2'd1;
    case (edge_q)
      2'd0: begin si = 2'd0; ei = 2'd1; end
      2'd1: begin si = 2'd1; ei = shape_q ? 2'd3 : 2'd2; end
      2'd2: begin si = shape_q ? 2'd3 : 2'd2; ei = shape_q ? 2'd2 : 2'd0; end
      default: begin si = 2'd2; ei = 2'd0; end
    endcase
  end

  logic [width-1:0]  xs, xe;
  logic [height-1:0] ys, ye;
  logic              last_edge;

  assign xs        = vx[si];
  assign xe        = vx[ei];
  assign ys        = vy[si];
  assign ye        = vy[ei];
  assign last_edge = shape_q ? (edge_q == 2'd3) : (edge_q == 2'd2);

  // Edge setup terms: dx >= 0, dy <= 0
  logic [width-1:0]       adx;
  logic [height-1:0]      ady;
  logic signed [width:0]  setup_dx;
  logic signed [height:0] setup_dy;
  logic signed [EW-1:0]   setup_err;

  assign adx       = (xe > xs) ? (xe - xs) : (xs - xe);
  assign ady       = (ye > ys) ? (ye - ys) : (ys - ye);
  assign setup_dx  = {1'b0, adx};
  assign setup_dy  = -$signed({1'b0, ady});
  assign setup_err = {{(EW-width-1){1'b0}}, setup_dx}
                   + {{(EW-height-1){setup_dy[height]}}, setup_dy};

  // Step decision uses e2 = 2*err, one bit wider than err so it never overflows
  logic signed [EW-1:0] dx_e, dy_e, err_nxt;
  logic signed [EW:0]   e2, dx_c, dy_c;
  logic                 step_x, step_y;
  logic [width-1:0]     nx;
  logic [height-1:0]    ny;

  assign dx_e    = {{(EW-width-1){dx_q[width]}}, dx_q};
  assign dy_e    = {{(EW-height-1){dy_q[height]}}, dy_q};
  assign dx_c    = {dx_e[EW-1], dx_e};
  assign dy_c    = {dy_e[EW-1], dy_e};
  assign e2      = {err_q, 1'b0};
  assign step_x  = (e2 >= dy_c);
  assign step_y  = (e2 <= dx_c);
  assign err_nxt = err_q + (step_x ? dy_e : '0) + (step_y ? dx_e : '0);
  assign nx      = step_x ? (sx_neg_q ? cur_x_q - 1'b1 : cur_x_q + 1'b1) : cur_x_q;
  assign ny      = step_y ? (sy_neg_q ? cur_y_q - 1'b1 : cur_y_q + 1'b1) : cur_y_q;

  always_comb begin
    state_d  = state_q;
    pts_d    = pts_q;
    shape_d  = shape_q;
    edge_d   = edge_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pts_d   = bus.points;
          shape_d = bus.shape;
          edge_d  = 2'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cur_x_d  = xs;
        cur_y_d  = ys;
        dx_d     = setup_dx;
        dy_d     = setup_dy;
        err_d    = setup_err;
        sx_neg_d = (xe < xs);
        sy_neg_d = (ye < ys);
        if ((xs == xe) && (ys == ye)) begin
          // zero-length edge contributes no pixels
          if (last_edge) state_d = DONE;
          else           edge_d  = edge_q + 2'd1;
        end else begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (bus.pix_ready) begin
          cur_x_d = nx;
          cur_y_d = ny;
          err_d   = err_nxt;
          // end vertex is not emitted; it is the start of the next edge
          if ((nx == xe) && (ny == ye)) begin
            if (last_edge) begin
              state_d = DONE;
            end else begin
              edge_d  = edge_q + 2'd1;
              state_d = SETUP;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pts_q    <= '0;
      shape_q  <= 1'b0;
      edge_q   <= 2'd0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pts_q    <= pts_d;
      shape_q  <= shape_d;
      edge_q   <= edge_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.pix_valid = (state_q == STEP);
  assign bus.pix_x     = cur_x_q;
  assign bus.pix_y     = cur_y_q;
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_shape_edge_walker.sv
// Self-checking bench for shape_edge_walker: directed table, backpressure,
// reset mid-walk and randomized shapes against a pixel-list reference model.
module tb_shape_edge_walker;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] exp_q [$];

  always #5 clk = ~clk;

  shape_edge_walker_if #(.width(4), .height(3)) bus ();

  shape_edge_walker #(.width(4), .height(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [27:0] pts;
    logic        shp;
    int          mode;      // 0: always ready, 1: ready pattern 1-0-0
    int          n;
    logic [83:0] lst;       // entry k = {y,x} at bits [7k +: 7]
    int          done_cyc;  // -1: not checked
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pk(input int x1, input int y1, input int x2, input int y2,
                                     input int x3, input int y3, input int x4, input int y4);
    return {3'(y4), 4'(x4), 3'(y3), 4'(x3), 3'(y2), 4'(x2), 3'(y1), 4'(x1)};
  endfunction

  function automatic logic [6:0] px(input int x, input int y);
    return {3'(y), 4'(x)};
  endfunction

  // Reference: fills exp_q with the outline pixels and returns the cycle
  // (counted from the accepting edge) at which done is expected with no stalls.
  function automatic int model(input logic [27:0] pts, input logic shp);
    int xv [4];
    int yv [4];
    int ord [4];
    int n, a, b, x, y, xe, ye, dx, dy, sx, sy, err, e2, cyc, guard;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      xv[i] = int'(pts[i*7 +: 4]);
      yv[i] = int'(pts[i*7+4 +: 3]);
    end
    if (shp) begin ord[0] = 0; ord[1] = 1; ord[2] = 3; ord[3] = 2; n = 4; end
    else     begin ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0; n = 3; end
    cyc = 1;
    for (int e = 0; e < n; e++) begin
      a = ord[e]; b = ord[(e+1) % n];
      x = xv[a]; y = yv[a]; xe = xv[b]; ye = yv[b];
      dx = (xe > x) ? xe - x : x - xe;
      dy = (ye > y) ? y - ye : ye - y;
      sx = (xe > x) ? 1 : -1;
      sy = (ye > y) ? 1 : -1;
      err = dx + dy;
      cyc++;
      guard = 0;
      while ((x != xe || y != ye) && guard < 64) begin
        exp_q.push_back(px(x, y));
        cyc++;
        guard++;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
    return cyc;
  endfunction

  // Issue one shape and follow it to done; exp_q must already hold the expected pixels.
  task automatic run_shape(input logic [27:0] pts, input logic shp, input int mode,
                           input int exp_done, input bit noise);
    int   cyc;
    bit   finished, stall, rdy;
    logic [6:0] prev;
    @(negedge clk);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.points = pts; bus.shape = shp; bus.in_valid = 1'b1; bus.pix_ready = 1'b1;
    @(posedge clk);
    cyc = 0; finished = 0; stall = 0; prev = '0;
    while (!finished && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.points   = 28'($urandom);
        bus.shape    = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 2);
        default: rdy = ($urandom_range(0, 99) < 60);
      endcase
      bus.pix_ready = rdy;
      if (cyc == 1) chk("setup_no_pix", int'(bus.pix_valid), 0);
      if (stall) begin
        chk("stall_valid", int'(bus.pix_valid), 1);
        chk("stall_hold", int'({bus.pix_y, bus.pix_x}), int'(prev));
      end
      if (bus.pix_valid && rdy) begin
        if (exp_q.size() == 0) chk("extra_pixel", int'({bus.pix_y, bus.pix_x}), -1);
        else                   chk("pixel", int'({bus.pix_y, bus.pix_x}), int'(exp_q.pop_front()));
      end
      stall = bus.pix_valid && !rdy;
      prev  = {bus.pix_y, bus.pix_x};
      if (bus.done) begin
        finished = 1;
        chk("in_ready_in_done", int'(bus.in_ready), 0);
        chk("pix_valid_in_done", int'(bus.pix_valid), 0);
        chk("missing_pixels", exp_q.size(), 0);
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
      end
    end
    bus.in_valid = 1'b0;
    if (!finished) chk("done_timeout", cyc, -1);
    @(negedge clk);
    chk("done_single_pulse", int'(bus.done), 0);
    chk("in_ready_after_done", int'(bus.in_ready), 1);
  endtask

  vec_t tbl [5];

  initial begin
    int cnt;
    bit hit;
    logic [27:0] rp;
    logic rs;
    int md, dc;

    tbl[0] = '{pk(0,0, 1,0, 0,1, 1,1), 1'b1, 0, 4,
               84'({px(0,1), px(1,1), px(1,0), px(0,0)}), 9};
    tbl[1] = '{pk(0,0, 3,0, 0,3, 0,0), 1'b0, 0, 9,
               84'({px(0,1), px(0,2), px(0,3), px(1,2), px(2,1), px(3,0), px(2,0), px(1,0), px(0,0)}), 13};
    tbl[2] = '{pk(0,0, 3,0, 0,3, 0,0), 1'b0, 1, 9,
               84'({px(0,1), px(0,2), px(0,3), px(1,2), px(2,1), px(3,0), px(2,0), px(1,0), px(0,0)}), -1};
    tbl[3] = '{pk(5,2, 5,2, 5,2, 5,2), 1'b0, 0, 0, 84'(0), 4};
    tbl[4] = '{pk(14,6, 15,6, 14,7, 15,7), 1'b1, 0, 4,
               84'({px(14,7), px(15,7), px(15,6), px(14,6)}), 9};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.points = '0; bus.shape = 1'b0; bus.pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_pix_valid", int'(bus.pix_valid), 0);
    chk("rst_pix_x", int'(bus.pix_x), 0);
    chk("rst_pix_y", int'(bus.pix_y), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;

    // directed table with hand-written expected pixel lists
    for (int t = 0; t < 5; t++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[t].n; k++) exp_q.push_back(tbl[t].lst[k*7 +: 7]);
      run_shape(tbl[t].pts, tbl[t].shp, tbl[t].mode, tbl[t].done_cyc, 1'b0);
    end

    // reset during STEP of the second triangle edge
    @(negedge clk);
    bus.points = pk(0,0, 3,0, 0,3, 0,0); bus.shape = 1'b0;
    bus.in_valid = 1'b1; bus.pix_ready = 1'b1;
    @(posedge clk);
    cnt = 0; hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.pix_valid) begin
        cnt++;
        if (cnt == 5) begin
          chk("pre_reset_pixel", int'({bus.pix_y, bus.pix_x}), int'(px(2,1)));
          reset = 1'b1;
          hit = 1;
        end
      end
    end
    chk("reached_mid_walk", int'(hit), 1);
    @(negedge clk);
    chk("mid_rst_pix_valid", int'(bus.pix_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_done", int'(bus.done), 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(bus.pix_valid || bus.done), 0);
    end
    dc = model(pk(1,1, 7,4, 2,6, 0,0), 1'b0);
    run_shape(pk(1,1, 7,4, 2,6, 0,0), 1'b0, 0, dc, 1'b0);

    // randomized shapes, stalls and ignored in_valid traffic while busy
    for (int r = 0; r < 60; r++) begin
      rp = 28'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 5) == 0) rp[13:7] = rp[6:0];
      md = ($urandom_range(0, 1) == 0) ? 0 : 2;
      dc = model(rp, rs);
      run_shape(rp, rs, md, (md == 0) ? dc : -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shape_edge_walker.md
Name: shape_edge_walker

Overview:
- Consumes the packed vertex word produced by the instruction-processing stage and rasterises the shape outline.
- Walks each polygon edge with Bresenham stepping and emits one pixel coordinate per cycle to the framebuffer writer.
- Sits directly downstream of processInstruction, with valid/ready handshakes on both sides.

Parameters:
width, 4, bit width of every x coordinate
height, 3, bit width of every y coordinate

Ports:
clk  input  1  system clock, rising edge
reset  input  1  reset, synchronous, active-high
in_valid  input  1  points/shape word valid
in_ready  output  1  block can accept a new shape
points  input  4*(width+height)  packed {y4,x4,y3,x3,y2,x2,y1,x1}; x1 in LSBs; each x is width bits, each y is height bits
shape  input  1  0 = triangle (P1,P2,P3; P4 ignored), 1 = square (P4 valid)
pix_valid  output  1  pixel coordinate valid
pix_ready  input  1  downstream accepts pixel
pix_x  output  width  pixel x
pix_y  output  height  pixel y
done  output  1  one-cycle pulse when the shape outline is complete

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state IDLE, in_ready=1, pix_valid=0, pix_x=0, pix_y=0, done=0. All internal registers are cleared.
- Reset mid-walk abandons the shape; no further pixels or done pulse are produced for it.
- FSM states: IDLE, SETUP, STEP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch points and shape, set edge index=0, go to SETUP.
- Edge order:
  - Triangle: P1→P2, P2→P3, P3→P1.
  - Square: P1→P2, P2→P4, P4→P3, P3→P1.
- SETUP (1 cycle, pix_valid=0):
  - Load cur=start.
  - dx=|xe-xs|, sx=sign(xe-xs); dy=-|ye-ys|, sy=sign(ye-ys); err=dx+dy.
  - Signed internal widths: width+1 for dx, height+1 for dy, max(width,height)+2 for err.
  - If start==end (zero-length edge): emit nothing; go to the next edge's SETUP, or to DONE if this was the last edge.
  - Otherwise go to STEP.
- STEP:
  - pix_valid=1, pix_x/pix_y=cur.
  - Outputs hold stable while pix_valid&&!pix_ready.
  - On acceptance: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy (both may apply in the same step).
  - If the updated cur==end, the edge is finished: go to the next edge's SETUP, or to DONE after the last edge.
  - The end vertex is excluded from each edge, so every vertex is emitted exactly once as the start of its outgoing edge.
- DONE (1 cycle): done=1, in_ready=0, then return to IDLE.
- in_ready=0 in every state except IDLE; an in_valid pulse outside IDLE is ignored.
- Latency:
  - Handshake accepted at edge N → SETUP during cycle N+1 → first pix_valid during cycle N+2.
  - With no backpressure, each edge costs 1 SETUP cycle plus 1 cycle per pixel.
- Coordinates never leave [0, 2^width-1]×[0, 2^height-1], because steps stop exactly at the edge endpoint.

Test Plan:
- Square P1=(0,0), P2=(1,0), P3=(0,1), P4=(1,1), pix_ready=1, accept at cycle 0 → pixels (0,0)@2, (1,0)@4, (1,1)@6, (0,1)@8; done@9; in_ready@10.
- Triangle P1=(0,0), P2=(3,0), P3=(0,3) → exactly 9 pixels in order: (0,0),(1,0),(2,0),(3,0),(2,1),(1,2),(0,3),(0,2),(0,1); then a single done pulse.
- Backpressure: same triangle with pix_ready toggled 1-0-0-1… → pix_x/pix_y/pix_valid held stable while stalled; identical 9-pixel sequence; no pixel dropped or duplicated.
- Degenerate triangle (all points (5,2)) → no pix_valid ever asserted; SETUP cycles 1-3, done@4, in_ready@5.
- Boundary square P1=(14,6), P2=(15,6), P3=(14,7), P4=(15,7) with width=4, height=3 → pixels (14,6),(15,6),(15,7),(14,7); no wrap to 0.
- Reset asserted during STEP of the second triangle edge → next cycle pix_valid=0, in_ready=1, done=0; a new shape accepted afterwards walks correctly from its P1.
